reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Multi-channel boot/reset sequencer: asserts NUM_CHANNELS reset outputs together,
//  holds them HOLD_CYCLES, then releases them one at a time in index order, STAGGER_CYCLES apart.
//  Supports a global restart and per-channel soft resets.
//  Sits at the top level between the board clock and the controller/DUT sub-blocks,
//  e.g. ch0 = interconnect, ch1 = memory, ch2 = core.
// PARAMETERS
//  NUM_CHANNELS   4   number of independent reset outputs (>=1)
//  CNT_WIDTH      8   width of the hold/stagger counters
//  HOLD_CYCLES    20  cycles all channels stay in reset, and per-channel soft-reset length (1..2^CNT_WIDTH-1)
//  STAGGER_CYCLES 4   cycles between successive channel releases (1..2^CNT_WIDTH-1)
// PORTS
//  clk         in   1             system clock, all logic on posedge
//  rst_n       in   1             synchronous active-low reset
//  start_i     in   1             restart request, sampled every edge
//  chan_req_i  in   NUM_CHANNELS  per-channel soft-reset request, level-sampled
//  rst_o       out  NUM_CHANNELS  active-high reset per channel (registered)
//  rst_n_o     out  NUM_CHANNELS  ~rst_o (combinational)
//  busy_o      out  1             |rst_o (combinational)
//  done_o      out  1             full boot sequence completed (registered)
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge):
//    - state=HOLD, counter=0, rst_o='1, done_o=0, per-channel counters=0.
//    - rst_o is therefore all-ones from the first clocked reset.
//  - FSM states:
//    - HOLD: counter runs; after HOLD_CYCLES edges -> RELEASE with idx=0.
//    - RELEASE: clear rst_o[idx]; wait STAGGER_CYCLES; idx++; after the last channel -> RUN.
//    - RUN: steady state; only soft resets are active here.
//    - Illegal encoding -> HOLD with all rst_o asserted.
//  - Exact timing: number edges 1,2,... starting at the first edge with rst_n=1.
//    - rst_o[k] falls at edge HOLD_CYCLES + k*STAGGER_CYCLES.
//    - done_o rises at the same edge as the last channel's release.
//  - start_i=1 at an edge, in any state:
//    - Next cycle: rst_o='1, done_o=0, state=HOLD, counter=0, soft-reset counters cleared.
//    - Timing then restarts, with that edge as edge 0.
//    - start_i held high keeps every channel in reset. start_i has priority over chan_req_i.
//  - chan_req_i[k]=1 at an edge:
//    - Acted on in RUN only; ignored in HOLD/RELEASE.
//    - rst_o[k]=1 from the next cycle, for exactly HOLD_CYCLES cycles, then 0.
//    - A new request while active reloads channel k's counter (extends).
//    - Channels are independent. done_o stays 1 during soft resets.
//  - Counters never wrap: they saturate/clear at their terminal value.
//  - Terminal compares use CNT_WIDTH-bit unsigned arithmetic.
//  - rst_n=0 mid-sequence aborts immediately to the reset values above.
// TESTING
//  1. N=4, HOLD=20, STAGGER=4; release rst_n:
//     -> rst_o[0..3] fall at edges 20/24/28/32; done_o=1 at 32; busy_o=0 after 32.
//  2. Pulse start_i one cycle in RUN:
//     -> rst_o=4'hF next cycle, done_o=0; channel 0 releases 20 edges after the pulse.
//  3. Pulse start_i mid-RELEASE (after ch1 released):
//     -> all channels re-asserted; full 20/24/28/32 timing re-measured from the pulse.
//  4. In RUN pulse chan_req_i[2]:
//     -> only rst_o[2]=1 for 20 cycles; done_o stays 1; other channels unaffected.
//  5. In RUN pulse chan_req_i[1], re-pulse 10 cycles later:
//     -> rst_o[1] high for 30 cycles total.
//     Also: chan_req_i during HOLD -> ignored.
//  6. rst_n=0 for 1 cycle at edge 26:
//     -> rst_o=4'hF, done_o=0 next cycle; sequence restarts.
//     Also: N=1, HOLD=1, STAGGER=1 -> rst_o[0] falls at edge 1.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: multi-channel boot/reset sequencer.
//
// All channel resets are asserted together, held for HOLD_CYCLES edges, then released one at a
// time in index order, STAGGER_CYCLES edges apart. Once every channel is released, the block
// sits in RUN. In RUN, each channel can be soft-reset on its own for HOLD_CYCLES cycles. A
// restart request, or the synchronous reset, rewinds the whole sequence.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   rst_n       in   synchronous active-low reset
//   start_i     in   restart request, sampled every edge (priority over chan_req_i)
//   chan_req_i  in   per-channel soft-reset request, level-sampled, honoured in RUN only
//   rst_o       out  active-high reset per channel (registered)
//   rst_n_o     out  ~rst_o
//   busy_o      out  any channel in reset
//   done_o      out  boot sequence completed (registered)
module reset_sequencer #(
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned CNT_WIDTH      = 8,
    parameter int unsigned HOLD_CYCLES    = 20,
    parameter int unsigned STAGGER_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [NUM_CHANNELS-1:0] chan_req_i,
    output logic [NUM_CHANNELS-1:0] rst_o,
    output logic [NUM_CHANNELS-1:0] rst_n_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    // Counters compare against "last" values so a phase lasting C edges ends when the counter,
    // started at zero, reaches C-1 on the final edge of that phase.
    localparam logic [CNT_WIDTH-1:0]    HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]    STAG_LAST = CNT_WIDTH'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [NUM_CHANNELS-1:0] FIRST_CH  = NUM_CHANNELS'(1);

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2
    } state_e;

    state_e                    state_q;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic [IDX_W-1:0]          idx_q;
    logic [NUM_CHANNELS-1:0]   rst_q;
    logic                      done_q;
    logic [CNT_WIDTH-1:0]      soft_cnt_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]   rel_mask;

    // One-hot of the channel due for release in RELEASE.
    always_comb begin
        rel_mask = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            rel_mask[k] = (idx_q == IDX_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || start_i) begin
            state_q <= StHold;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                soft_cnt_q[k] <= '0;
            end
        end else begin
            case (state_q)
                StHold: begin
                    if (cnt_q == HOLD_LAST) begin
                        // Channel 0 is released on the final hold edge itself.
                        cnt_q <= '0;
                        rst_q <= rst_q & ~FIRST_CH;
                        if (NUM_CHANNELS == 1) begin
                            state_q <= StRun;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRelease;
                            idx_q   <= IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                StRelease: begin
                    if (cnt_q == STAG_LAST) begin
                        cnt_q <= '0;
                        rst_q <= rst_q & ~rel_mask;
                        if (idx_q == IDX_LAST) begin
                            state_q <= StRun;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                StRun: begin
                    // In RUN a set rst_q bit can only be an active soft reset.
                    for (int k = 0; k < NUM_CHANNELS; k++) begin
                        if (chan_req_i[k]) begin
                            rst_q[k]      <= 1'b1;
                            soft_cnt_q[k] <= HOLD_LAST;
                        end else if (rst_q[k]) begin
                            if (soft_cnt_q[k] == '0) begin
                                rst_q[k] <= 1'b0;
                            end else begin
                                soft_cnt_q[k] <= soft_cnt_q[k] - CNT_WIDTH'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_q <= StHold;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    rst_q   <= '1;
                    done_q  <= 1'b0;
                    for (int k = 0; k < NUM_CHANNELS; k++) begin
                        soft_cnt_q[k] <= '0;
                    end
                end
            endcase
        end
    end

    assign rst_o   = rst_q;
    assign rst_n_o = ~rst_q;
    assign busy_o  = |rst_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int N      = 4;
    localparam int H      = 20;
    localparam int S      = 4;
    localparam int T_LAST = H + (N - 1) * S;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n   = 1'b0;
    logic         start   = 1'b0;
    logic [N-1:0] req     = '0;
    logic [N-1:0] rst_o;
    logic [N-1:0] rst_n_o;
    logic         busy;
    logic         done;

    logic       s_rst_n = 1'b0;
    logic       s_start = 1'b0;
    logic [0:0] s_req   = 1'b0;
    logic [0:0] s_rst_o;
    logic [0:0] s_rst_n_o;
    logic       s_busy;
    logic       s_done;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .NUM_CHANNELS  (N),
        .CNT_WIDTH     (8),
        .HOLD_CYCLES   (H),
        .STAGGER_CYCLES(S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .chan_req_i(req),
        .rst_o     (rst_o),
        .rst_n_o   (rst_n_o),
        .busy_o    (busy),
        .done_o    (done)
    );

    reset_sequencer #(
        .NUM_CHANNELS  (1),
        .CNT_WIDTH     (8),
        .HOLD_CYCLES   (1),
        .STAGGER_CYCLES(1)
    ) dut_small (
        .clk       (clk),
        .rst_n     (s_rst_n),
        .start_i   (s_start),
        .chan_req_i(s_req),
        .rst_o     (s_rst_o),
        .rst_n_o   (s_rst_n_o),
        .busy_o    (s_busy),
        .done_o    (s_done)
    );

    // Reference model: t counts edges since the last reset/restart edge (edge 0). Channel k is
    // in boot reset while t < H + k*S; a soft reset accepted at edge E keeps it high while
    // t < E + H. Boot is complete once t >= T_LAST.
    int t = 0;
    int soft_end [N];

    always @(posedge clk) begin
        if (!rst_n || start) begin
            t <= 0;
            for (int k = 0; k < N; k++) soft_end[k] <= 0;
        end else begin
            t <= (t < 1000000) ? t + 1 : t;
            for (int k = 0; k < N; k++) begin
                if (req[k] && t >= T_LAST) soft_end[k] <= t + 1 + H;
            end
        end
    end

    function automatic logic [2*N+1:0] expected();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = (t < H + k * S) || (t < soft_end[k]);
        return {r, ~r, |r, (t >= T_LAST)};
    endfunction

    logic [2*N+1:0] obs;
    assign obs = {rst_o, rst_n_o, busy, done};

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== expected() || rst_o !== 4'hF || done !== 1'b0) begin
            $display("FAIL reset: got %b want %b", obs, expected());
            errors++;
        end
    endtask

    task automatic test_boot();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== expected()) begin
                $display("FAIL boot t=%0d: got %b want %b", t, obs, expected());
                errors++;
            end
        end
    endtask

    task automatic test_start_run();
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (obs !== expected()) begin
                $display("FAIL start_run t=%0d: got %b want %b", t, obs, expected());
                errors++;
            end
        end
    endtask

    task automatic test_start_release();
        start = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (obs !== expected()) begin
                $display("FAIL pre_restart t=%0d: got %b want %b", t, obs, expected());
                errors++;
            end
        end
        // Next edge is edge 26, after channel 1 has been released.
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (obs !== expected()) begin
                $display("FAIL start_release t=%0d: got %b want %b", t, obs, expected());
                errors++;
            end
        end
    endtask

    task automatic test_soft();
        int hi2 = 0;
        int hi1 = 0;
        req = 4'b0100;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            req = '0;
            if (rst_o[2]) hi2++;
            checks++;
            if (obs !== expected() || done !== 1'b1) begin
                $display("FAIL soft_ch2 t=%0d: got %b want %b", t, obs, expected());
                errors++;
            end
        end
        checks++;
        if (hi2 !== H) begin
            $display("FAIL soft_ch2_len: got %0d want %0d", hi2, H);
            errors++;
        end
        req = 4'b0010;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            req = (i == 9) ? 4'b0010 : 4'b0000;
            if (rst_o[1]) hi1++;
            checks++;
            if (obs !== expected() || done !== 1'b1) begin
                $display("FAIL soft_ch1 t=%0d: got %b want %b", t, obs, expected());
                errors++;
            end
        end
        checks++;
        if (hi1 !== H + 10) begin
            $display("FAIL soft_extend_len: got %0d want %0d", hi1, H + 10);
            errors++;
        end
    endtask

    task automatic test_req_in_hold();
        start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            start = 1'b0;
            req   = (t < T_LAST) ? N'($urandom_range(1, (1 << N) - 1)) : '0;
            checks++;
            if (obs !== expected()) begin
                $display("FAIL req_in_hold t=%0d: got %b want %b", t, obs, expected());
                errors++;
            end
        end
        req = '0;
    endtask

    task automatic test_rst_mid();
        start = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        // Next edge is edge 26.
        rst_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            checks++;
            if (obs !== expected()) begin
                $display("FAIL rst_mid t=%0d: got %b want %b", t, obs, expected());
                errors++;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== expected()) begin
                $display("FAIL random i=%0d t=%0d: got %b want %b", i, t, obs, expected());
                errors++;
            end
            rst_n = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 149) == 0);
            req   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
        end
        rst_n = 1'b1;
        start = 1'b0;
        req   = '0;
    endtask

    task automatic test_small();
        s_rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (s_rst_o !== 1'b1 || s_done !== 1'b0 || s_busy !== 1'b1) begin
            $display("FAIL small_reset: got rst=%b done=%b busy=%b want 1 0 1",
                     s_rst_o, s_done, s_busy);
            errors++;
        end
        s_rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_rst_o !== 1'b0 || s_rst_n_o !== 1'b1 || s_done !== 1'b1 || s_busy !== 1'b0) begin
            $display("FAIL small_edge1: got rst=%b done=%b busy=%b want 0 1 0",
                     s_rst_o, s_done, s_busy);
            errors++;
        end
        s_req = 1'b1;
        @(negedge clk);
        s_req = 1'b0;
        checks++;
        if (s_rst_o !== 1'b1 || s_done !== 1'b1) begin
            $display("FAIL small_soft_on: got rst=%b done=%b want 1 1", s_rst_o, s_done);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (s_rst_o !== 1'b0 || s_done !== 1'b1) begin
            $display("FAIL small_soft_off: got rst=%b done=%b want 0 1", s_rst_o, s_done);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_start_run();
        test_start_release();
        test_soft();
        test_req_in_hold();
        test_rst_mid();
        test_random();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
